div: RTL and testbench

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX drives both operands, the signedness flag and a start level. It stalls the pipeline until this block raises `ready_o`, then writes `result_o` into HI/LO. The block uses restoring division: one quotient bit per cycle, 32 iteration cycles, plus fixed setup and finish cycles.

---
 rtl/div.sv | 139 +++++++++++++
 tb/tb_div.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// div: multi-cycle restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// Define DIV_ANNUL_EN to add the annul_i abort port.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
`ifdef DIV_ANNUL_EN
  input  logic        annul_i,
`endif
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt, cnt_next;
  logic [64:0] work, work_next;
  logic [31:0] divisor, divisor_next;
  logic        sgn, sgn_next;
  logic        neg1, neg1_next;
  logic        neg2, neg2_next;
  logic [63:0] result_next;
  logic        ready_next;
  logic        annul;

`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  assign annul = 1'b0;
`endif

  logic [31:0] abs1, abs2;
  logic [32:0] diff;
  logic [31:0] quo_fin, rem_fin;

  // The core iterates on magnitudes; signs are reapplied once at the end.
  assign abs1    = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs2    = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  assign diff    = work[64:32] - {1'b0, divisor};
  assign quo_fin = (sgn && (neg1 ^ neg2)) ? (~work[31:0] + 32'd1) : work[31:0];
  assign rem_fin = (sgn && neg1) ? (~work[64:33] + 32'd1) : work[64:33];

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    work_next    = work;
    divisor_next = divisor;
    sgn_next     = sgn;
    neg1_next    = neg1;
    neg2_next    = neg2;
    result_next  = result_o;
    ready_next   = ready_o;
    case (state)
      FREE: begin
        ready_next  = 1'b0;
        result_next = 64'd0;
        if (start_i && !annul) begin
          if (opdata2_i == 32'd0) begin
            state_next = BYZERO;
          end else begin
            state_next   = ON;
            cnt_next     = 6'd0;
            divisor_next = abs2;
            work_next    = {32'd0, abs1, 1'b0};
            sgn_next     = signed_div_i;
            neg1_next    = opdata1_i[31];
            neg2_next    = opdata2_i[31];
          end
        end
      end
      BYZERO: begin
        if (annul) begin
          state_next = FREE;
          cnt_next   = 6'd0;
        end else begin
          state_next  = END;
          result_next = 64'd0;
          ready_next  = 1'b1;
        end
      end
      ON: begin
        if (annul) begin
          state_next  = FREE;
          cnt_next    = 6'd0;
          ready_next  = 1'b0;
          result_next = 64'd0;
        end else if (cnt != 6'd32) begin
          // Restore on a negative trial difference by simply not keeping it.
          if (diff[32])
            work_next = {work[63:0], 1'b0};
          else
            work_next = {diff[31:0], work[31:0], 1'b1};
          cnt_next = cnt + 6'd1;
        end else begin
          state_next  = END;
          result_next = {rem_fin, quo_fin};
          ready_next  = 1'b1;
        end
      end
      END: begin
        if (!start_i) begin
          state_next  = FREE;
          ready_next  = 1'b0;
          result_next = 64'd0;
        end
      end
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      work     <= 65'd0;
      divisor  <= 32'd0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      work     <= work_next;
      divisor  <= divisor_next;
      sgn      <= sgn_next;
      neg1     <= neg1_next;
      neg2     <= neg2_next;
      result_o <= result_next;
      ready_o  <= ready_next;
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for div; expected results are queued at issue and
// checked by an independent monitor on each rising ready_o.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ANNUL_EN
  logic        annul_i = 1'b0;
`endif

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   accept_cyc = 0;
  logic ready_q    = 1'b0;

  div dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
`ifdef DIV_ANNUL_EN
    .annul_i     (annul_i),
`endif
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ready_o === 1'b1 && ready_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_ready: got ready_o=1 at cycle %0d, expected no result", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("result", result_o, e.res);
        checkOutput("latency", 64'(cyc - accept_cyc), 64'(e.lat));
      end
    end
    ready_q = ready_o;
  end

  // Drives one request, passes E0, then scrambles the operands to prove they are ignored.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] res, input int lat, input bit expect_done);
    exp_t e;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (expect_done) begin
      e.res = res;
      e.lat = lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    accept_cyc   = cyc;
    opdata1_i    = ~a;
    opdata2_i    = b ^ 32'h0000_0005;
    signed_div_i = ~sgn;
  endtask

  task automatic waitReady(input int hold, input logic [63:0] res);
    int n = 0;
    while (ready_o !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready_timeout: got ready_o=0 after %0d cycles, expected 1", n);
    end else begin
      repeat (hold) begin
        @(negedge clk);
        checkOutput("hold_ready", {63'd0, ready_o}, 64'd1);
        checkOutput("hold_result", result_o, res);
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("release_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("release_result", result_o, 64'd0);
    @(negedge clk);
  endtask

  task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] res, input int hold);
    applyStimulus(sgn, a, b, res, (b == 32'd0) ? 1 : 33, 1'b1);
    waitReady(hold, res);
  endtask

  task automatic expectQuiet(input string name, input int cycles);
    int highs = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ready_o !== 1'b0) highs++;
    end
    checkOutput(name, 64'(highs), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    runDiv(1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 0);
    runDiv(1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 0);
    runDiv(1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, 0);
    runDiv(1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 0);
    runDiv(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 0);
    runDiv(1'b0, 32'd5,          32'd0,          64'd0,                 1);
    runDiv(1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 0);
    runDiv(1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 0);
    runDiv(1'b0, 32'd1234,       32'd1,          64'h00000000_000004D2, 5);
    runDiv(1'b0, 32'hFFFFFFFF,   32'h00000010,   64'h0000000F_0FFFFFFF, 0);

`ifdef DIV_ANNUL_EN
    // Abort at iteration 10; the request must never report ready.
    applyStimulus(1'b0, 32'd100, 32'd7, 64'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    checkOutput("annul_ready", {63'd0, ready_o}, 64'd0);
    expectQuiet("annul_quiet", 40);
    // A start presented together with annul is refused.
    @(negedge clk);
    start_i = 1'b1;
    annul_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    expectQuiet("annul_refuse_quiet", 40);
`endif

    // Reset at iteration 20 of a division wipes it out.
    applyStimulus(1'b0, 32'd100, 32'd7, 64'd0, 0, 1'b0);
    repeat (19) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("midrst_result", result_o, 64'd0);
    expectQuiet("midrst_quiet", 40);

    runDiv(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);

    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
